// File: rtl/bram_tree_pkg.sv
// Types and default constants shared by bram_tree, its feeder front-end and their benches.
package bram_tree_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 32;
  localparam int DEFAULT_FIFO_DEPTH  = 4;
  localparam int DEFAULT_INIT_CYCLES = 80;
  localparam int DEFAULT_REPLACE_GAP = 10;

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    IDLE   = 2'd1,
    SETTLE = 2'd2
  } feeder_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bram_tree_feeder_if.sv
// Valid/ready item stream; master drives valid/data, slave drives ready.
interface bram_tree_feeder_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/bram_tree_in_fifo.sv
// Small circular FIFO with a fall-through head; pushes into a full FIFO and
// pops from an empty one are ignored.
module bram_tree_in_fifo
  import bram_tree_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [DATA_WIDTH-1:0]       push_data,
  input  logic                        pop,
  output logic [DATA_WIDTH-1:0]       head_data,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  push_ok;
  logic                  pop_ok;

  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;

  // Depth is a power of two, so the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/bram_tree_feeder.sv
// Front-end for bram_tree: buffers items, spaces replace pulses to the tree and
// streams each evicted top item downstream.
module bram_tree_feeder
  import bram_tree_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH,
  parameter int INIT_CYCLES = DEFAULT_INIT_CYCLES,
  parameter int REPLACE_GAP = DEFAULT_REPLACE_GAP
) (
  input  logic                  clk,
  input  logic                  rst,
  bram_tree_feeder_if.slave     in_s,
  bram_tree_feeder_if.master    out_m,
  output logic                  replace,
  output logic [DATA_WIDTH-1:0] new_item,
  input  logic [DATA_WIDTH-1:0] top_item,
  output logic                  busy
);

  localparam int CNT_MAX = max_int(INIT_CYCLES, REPLACE_GAP);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int FCW     = $clog2(FIFO_DEPTH) + 1;

  feeder_state_t         state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  replace_q, replace_d;
  logic [DATA_WIDTH-1:0] new_item_q, new_item_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  logic                  fifo_push;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FCW-1:0]        fifo_count;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  slot_free;
  logic                  issue;

  // Ready depends only on occupancy, never on in_s.valid.
  assign in_s.ready = (fifo_count != FCW'(FIFO_DEPTH));
  assign fifo_push  = in_s.valid && !fifo_full;

  bram_tree_in_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (in_s.data),
    .pop       (issue),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign slot_free = !out_valid_q || out_m.ready;
  assign issue     = (state_q == IDLE) && !fifo_empty && slot_free;

  always_comb begin
    state_d = state_q;
    case (state_q)
      WARMUP:  if (cnt_q == '0) state_d = IDLE;
      IDLE:    if (issue)       state_d = SETTLE;
      SETTLE:  if (cnt_q == '0) state_d = IDLE;
      default: state_d = WARMUP;
    endcase
  end

  // An issue evicts the current tree top into the output slot in the same edge,
  // so a downstream transfer and a new issue can overlap without a bubble.
  always_comb begin
    cnt_d       = cnt_q;
    replace_d   = 1'b0;
    new_item_d  = new_item_q;
    out_valid_d = out_valid_q && !out_m.ready;
    out_data_d  = out_data_q;
    case (state_q)
      WARMUP, SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      IDLE: begin
        if (issue) begin
          replace_d   = 1'b1;
          new_item_d  = fifo_head;
          out_valid_d = 1'b1;
          out_data_d  = top_item;
          cnt_d       = CNT_W'(REPLACE_GAP - 1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= WARMUP;
      cnt_q       <= CNT_W'(INIT_CYCLES - 1);
      replace_q   <= 1'b0;
      new_item_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      replace_q   <= replace_d;
      new_item_q  <= new_item_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign replace    = replace_q;
  assign new_item   = new_item_q;
  assign out_m.valid = out_valid_q;
  assign out_m.data  = out_data_q;
  assign busy       = (state_q != IDLE);

endmodule
